arb_rr16: RTL and testbench
===========================

Name: arb_rr16

Overview:
- 16-requester round-robin arbiter that shares one downstream resource, such as the shared 16-to-4 encoded ID bus or a shared datapath port.
- Picks one requester and registers its 4-bit ID and one-hot grant.
- Holds the grant for a bounded number of cycles, then rotates priority so that no requester starves.
- Sits between the request sources and the shared resource; enable semantics match the team's encoder blocks: en low means no new output.

Parameters:
HOLD_MAX, 8, maximum consecutive GRANT cycles per grant (1..255)
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  arbiter enable
req  input  16  request vector; bit i = requester i
gnt  output  16  one-hot grant, registered
gnt_id  output  4  encoded index of the granted requester, registered
gnt_valid  output  1  high while in GRANT
busy_cnt  output  CNT_W  cycles spent in the current grant, starting from 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_valid=0, busy_cnt=0.
  - Reset applied mid-grant drops the grant on the next edge.
- Selection is combinational: first i in the order ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16) with req[i]=1.
- IDLE:
  - If en=1 and req≠0, go to GRANT on the next edge.
  - Load gnt_id=sel, gnt=1<<sel, gnt_valid=1, busy_cnt=0.
  - Latency from req to gnt is 1 cycle.
  - Otherwise stay in IDLE with outputs at 0.
- GRANT, checked each edge in priority order:
  1. en=0 → release.
  2. req[gnt_id]=0 → release.
  3. busy_cnt==HOLD_MAX-1 → release (forced rotation).
  4. Otherwise busy_cnt+1 and hold; gnt and gnt_id stay stable.
- Release (one edge):
  - state=IDLE; gnt, gnt_id, gnt_valid and busy_cnt go to 0.
  - ptr=gnt_id+1, wrapping 15→0 in 4-bit arithmetic.
- Every grant is followed by exactly one IDLE cycle. The resource therefore always sees a gap, and back-to-back grants to the same requester are impossible while other requesters are pending.
- Req changes on non-granted bits during GRANT are ignored until IDLE.
- HOLD_MAX=1: every grant lasts exactly 1 cycle.
- gnt always equals 1<<gnt_id when gnt_valid=1, and gnt=0 otherwise.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - Adds input lock (1 bit).
  - In GRANT with lock=1 and req[gnt_id]=1, the HOLD_MAX forced release is suppressed and busy_cnt saturates at HOLD_MAX-1.
  - en=0 or req drop still release.
- When undefined: no lock port; the forced release always applies.

Decomposition:
- Shared package arb_pkg:
  - state enum/localparams ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Constant N_REQ=16.
  - Constant ID_W=4.
- One natural sub-module, rr_sel16: purely combinational rotate + priority-encode (req, ptr → sel, any).
  - Implementation: rotate req right by ptr, find the lowest set bit with a for loop, add ptr back mod 16.

Test Plan:
- Reset check: rst=1 with req=16'hFFFF, en=1 → gnt=0, gnt_id=0, gnt_valid=0. After rst drops, the next edge gives gnt_id=0, gnt=16'h0001.
- Rotation: req=16'h8001 held, HOLD_MAX=8, en=1.
  - Grant 0 for 8 cycles, 1 IDLE, grant 15 for 8 cycles, 1 IDLE, grant 0.
  - busy_cnt counts 0..7 each grant.
- Early release: req=16'h0010 → gnt_id=4. Drop req[4] after 3 cycles → release next edge, ptr=5. Then req=16'h0018 → gnt_id=3 (first from 5 with wrap).
- Wrap: last grant was 15 (ptr=0), req=16'h8002 → gnt_id=1; a 15 request issued alone afterwards is granted after release.
- Enable: en=0 with req=16'h0100 → no grant. en=1 → gnt_id=8 after 1 cycle. en=0 mid-grant → release next edge, ptr=9.
- Lock (ARB_LOCK_EN): req=16'h0003, lock=1 → requester 0 held beyond 8 cycles with busy_cnt stuck at 7. Lock=0 → release next edge, then requester 1 granted.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-requester round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

endpackage

// File: rtl/rr_sel16.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 16.
module rr_sel16
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  sel,
  output logic             any
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_off;

  // Doubling the vector turns the rotate into a plain shift.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  always_comb begin
    w_off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = ID_W'(j);
    end
  end

  assign sel = w_off + ptr;
  assign any = |req;

endmodule

// File: rtl/arb_rr16.sv
// Round-robin arbiter with bounded hold and a mandatory IDLE gap after every grant.
// Define ARB_LOCK_EN to add a lock input that suppresses the forced rotation.
module arb_rr16
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] busy_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [ID_W-1:0]  r_gnt_id;
  logic             r_gnt_valid;
  logic [CNT_W-1:0] r_cnt;

  logic [ID_W-1:0]  w_sel;
  logic             w_any;
  logic             w_lock_hold;
  logic             w_release;

  rr_sel16 u_sel (
    .req (req),
    .ptr (r_ptr),
    .sel (w_sel),
    .any (w_any)
  );

`ifdef ARB_LOCK_EN
  assign w_lock_hold = lock & req[r_gnt_id];
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_release = !en || !req[r_gnt_id] || ((r_cnt == HOLD_LAST) && !w_lock_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && w_any) begin
            r_state     <= ST_GRANT;
            r_gnt_id    <= w_sel;
            r_gnt       <= N_REQ'(1) << w_sel;
            r_gnt_valid <= 1'b1;
            r_cnt       <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state     <= ST_IDLE;
            r_ptr       <= r_gnt_id + ID_W'(1);
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_cnt       <= '0;
          end else if (r_cnt != HOLD_LAST) begin
            // A locked grant parks the counter on its last value.
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign busy_cnt  = r_cnt;

endmodule

// File: tb/tb_arb_rr16.sv
// Scoreboard bench for arb_rr16: two instances (HOLD_MAX=8 and HOLD_MAX=1) against a reference model.
module tb_arb_rr16;

  localparam int NU = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] req = '0;
  logic        lock = 1'b0;

  logic [15:0] g0, g1;
  logic [3:0]  i0, i1;
  logic        v0, v1;
  logic [7:0]  c0, c1;

  always #5 clk = ~clk;

  arb_rr16 #(.HOLD_MAX(8), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .en(en),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req), .gnt(g0), .gnt_id(i0), .gnt_valid(v0), .busy_cnt(c0)
  );

  arb_rr16 #(.HOLD_MAX(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .en(en),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req), .gnt(g1), .gnt_id(i1), .gnt_valid(v1), .busy_cnt(c1)
  );

  typedef struct packed {
    logic [15:0] g0, g1;
    logic [3:0]  i0, i1;
    logic        v0, v1;
    logic [7:0]  c0, c1;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner of the resource (-1 when idle), hold length so far, priority start.
  int hold  [NU] = '{8, 1};
  int owner [NU];
  int held  [NU];
  int start [NU];

  task automatic model_step(input int u);
    int k, cand;
    if (rst) begin
      owner[u] = -1; held[u] = 0; start[u] = 0;
    end else if (owner[u] < 0) begin
      if (en && req != 16'h0) begin
        for (k = 0; k < 16; k++) begin
          cand = (start[u] + k) % 16;
          if (req[cand]) break;
        end
        owner[u] = cand;
        held[u]  = 0;
      end
    end else begin
      if (!en || !req[owner[u]] || (held[u] + 1 >= hold[u] && !lock_active())) begin
        start[u] = (owner[u] + 1) % 16;
        owner[u] = -1;
        held[u]  = 0;
      end else if (held[u] + 1 < hold[u]) begin
        held[u] = held[u] + 1;
      end
    end
  endtask

  function automatic bit lock_active();
`ifdef ARB_LOCK_EN
    return lock;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_gnt(input int u);
    return (owner[u] < 0) ? 16'h0 : (16'h1 << owner[u]);
  endfunction

  function automatic logic [3:0] exp_id(input int u);
    return (owner[u] < 0) ? 4'h0 : 4'(owner[u]);
  endfunction

  task automatic step(input logic r, input logic e_in, input logic [15:0] rq, input logic lk);
    exp_t x;
    @(negedge clk);
    #1;
    rst = r; en = e_in; req = rq; lock = lk;
    for (int u = 0; u < NU; u++) model_step(u);
    x.g0 = exp_gnt(0); x.i0 = exp_id(0); x.v0 = (owner[0] >= 0); x.c0 = 8'(held[0]);
    x.g1 = exp_gnt(1); x.i1 = exp_id(1); x.v1 = (owner[1] >= 0); x.c1 = 8'(held[1]);
    q.push_back(x);
  endtask

  task automatic steps(input int n, input logic r, input logic e_in, input logic [15:0] rq, input logic lk);
    for (int s = 0; s < n; s++) step(r, e_in, rq, lk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared half a cycle after it.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("h8_gnt",       32'(g0), 32'(e.g0));
      chk("h8_gnt_id",    32'(i0), 32'(e.i0));
      chk("h8_gnt_valid", 32'(v0), 32'(e.v0));
      chk("h8_busy_cnt",  32'(c0), 32'(e.c0));
      chk("h1_gnt",       32'(g1), 32'(e.g1));
      chk("h1_gnt_id",    32'(i1), 32'(e.i1));
      chk("h1_gnt_valid", 32'(v1), 32'(e.v1));
      chk("h1_busy_cnt",  32'(c1), 32'(e.c1));
    end
  end

  initial begin
    logic [15:0] rq;
    logic        en_r, lk_r;
    for (int u = 0; u < NU; u++) begin owner[u] = -1; held[u] = 0; start[u] = 0; end

    // Reset with everything requesting, then first grant to requester 0.
    steps(3, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    steps(4, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    steps(1, 1'b1, 1'b1, 16'hFFFF, 1'b0);

    // Rotation between requesters 0 and 15.
    steps(40, 1'b0, 1'b1, 16'h8001, 1'b0);
    steps(1, 1'b1, 1'b0, 16'h0000, 1'b0);

    // Early release and wrap-around search from ptr=5.
    steps(4, 1'b0, 1'b1, 16'h0010, 1'b0);
    steps(1, 1'b0, 1'b1, 16'h0000, 1'b0);
    steps(4, 1'b0, 1'b1, 16'h0018, 1'b0);
    steps(1, 1'b0, 1'b1, 16'h0000, 1'b0);

    // Wrap: grant 15, release, then 1 ahead of 15.
    steps(3, 1'b0, 1'b1, 16'h8000, 1'b0);
    steps(1, 1'b0, 1'b1, 16'h0000, 1'b0);
    steps(3, 1'b0, 1'b1, 16'h8002, 1'b0);
    steps(4, 1'b0, 1'b1, 16'h8000, 1'b0);

    // Enable gating and mid-grant disable.
    steps(3, 1'b0, 1'b0, 16'h0100, 1'b0);
    steps(3, 1'b0, 1'b1, 16'h0100, 1'b0);
    steps(2, 1'b0, 1'b0, 16'h0100, 1'b0);
    steps(3, 1'b0, 1'b1, 16'h0300, 1'b0);

`ifdef ARB_LOCK_EN
    steps(1, 1'b1, 1'b0, 16'h0000, 1'b0);
    steps(15, 1'b0, 1'b1, 16'h0003, 1'b1);
    steps(4, 1'b0, 1'b1, 16'h0003, 1'b0);
`endif

    // Randomised: requests held for random stretches, occasional disable/reset.
    rq = 16'h0; en_r = 1'b1; lk_r = 1'b0;
    for (int s = 0; s < 3000; s++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: rq = 16'($urandom);
          1: rq = 16'h1 << $urandom_range(0, 15);
          2: rq = 16'($urandom) & 16'($urandom);
          default: rq = rq ^ (16'h1 << $urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      if ($urandom_range(0, 9) == 0) lk_r = ~lk_r;
      step(($urandom_range(0, 299) == 0), en_r, rq, lk_r);
    end

    steps(2, 1'b0, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
